// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard unit for the integer pipeline.
// Forward selects are purely combinational from the producer stages; a
// per-register load scoreboard holds ID (and bubbles EX) until a load's
// result becomes forwardable, and a saturating counter tracks stall cycles.
module fwd_hazard_unit #(
  parameter int NUM_STAGES = 2,
  parameter int LOAD_LAT   = 1,
  parameter int CNTW       = 32,
  parameter int SELW       = $clog2(NUM_STAGES + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [31:0]             i_instr_ID,
  input  logic                    i_id_valid,
  input  logic                    i_id_uses_rs1,
  input  logic                    i_id_uses_rs2,
  input  logic                    i_id_is_load,
  input  logic [31:0]             i_instr_EX,
  input  logic                    i_ex_valid,
  input  logic [5*NUM_STAGES-1:0] i_stg_rd,
  input  logic [NUM_STAGES-1:0]   i_stg_wren,
  input  logic [NUM_STAGES-1:0]   i_stg_jump,
  input  logic                    i_flush,
  output logic [SELW-1:0]         o_fwd_a_sel,
  output logic [SELW-1:0]         o_fwd_b_sel,
  output logic                    o_pc_four_a,
  output logic                    o_pc_four_b,
  output logic                    o_stall_id,
  output logic                    o_bubble_ex,
  output logic [CNTW-1:0]         o_stall_cnt
);

  localparam int PW = $clog2(LOAD_LAT + 1);

  logic [4:0] ex_rs1, ex_rs2;
  logic [4:0] id_rs1, id_rs2, id_rd;

  assign ex_rs1 = i_instr_EX[19:15];
  assign ex_rs2 = i_instr_EX[24:20];
  assign id_rs1 = i_instr_ID[19:15];
  assign id_rs2 = i_instr_ID[24:20];
  assign id_rd  = i_instr_ID[11:7];

  // Opcode/funct bits are not needed here; fold them into a sink.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{i_instr_ID[31:25], i_instr_ID[14:12], i_instr_ID[6:0],
                               i_instr_EX[31:25], i_instr_EX[14:0]};

  // Forward select: scan oldest to youngest so the lowest matching stage wins.
  always_comb begin
    o_fwd_a_sel = '0;
    o_fwd_b_sel = '0;
    o_pc_four_a = 1'b0;
    o_pc_four_b = 1'b0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (i_ex_valid && i_stg_wren[k] && (i_stg_rd[5*k +: 5] != 5'd0)) begin
        if (i_stg_rd[5*k +: 5] == ex_rs1) begin
          o_fwd_a_sel = SELW'(k + 1);
          o_pc_four_a = i_stg_jump[k];
        end
        if (i_stg_rd[5*k +: 5] == ex_rs2) begin
          o_fwd_b_sel = SELW'(k + 1);
          o_pc_four_b = i_stg_jump[k];
        end
      end
    end
  end

  // pend[r] != 0: r's load data cannot yet be forwarded to the next EX entrant.
  logic [PW-1:0] pend [32];
  logic          last_ld_v;
  logic [4:0]    last_ld_rd;

  logic rs1_busy, rs2_busy;
  logic issue, ld_issue, kill_ld;

  // Hazard detect and issue qualification from registered scoreboard state.
  always_comb begin
    rs1_busy    = i_id_uses_rs1 && (id_rs1 != 5'd0) && (pend[id_rs1] != '0);
    rs2_busy    = i_id_uses_rs2 && (id_rs2 != 5'd0) && (pend[id_rs2] != '0);
    o_stall_id  = i_id_valid && !i_flush && (rs1_busy || rs2_busy);
    o_bubble_ex = o_stall_id;
    issue       = i_id_valid && !o_stall_id && !i_flush;
    ld_issue    = issue && i_id_is_load && (id_rd != 5'd0);
    // A flush kills the load that issued last cycle (now in EX).
    kill_ld     = i_flush && last_ld_v;
  end

  // Scoreboard update: kill beats a fresh set, which beats the countdown.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int r = 0; r < 32; r++) pend[r] <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (kill_ld && (last_ld_rd == 5'(r)))
          pend[r] <= '0;
        else if (ld_issue && (id_rd == 5'(r)))
          pend[r] <= PW'(LOAD_LAT);
        else if (pend[r] != '0)
          pend[r] <= pend[r] - 1'b1;
      end
    end
  end

  // Remember the load that issued this cycle so a flush next cycle can undo it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      last_ld_v  <= 1'b0;
      last_ld_rd <= 5'd0;
    end else begin
      last_ld_v  <= ld_issue;
      last_ld_rd <= id_rd;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      o_stall_cnt <= '0;
    else if (o_stall_id && (o_stall_cnt != '1))
      o_stall_cnt <= o_stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: three instances (LOAD_LAT 1, 3, and 4 with a
// 4-bit counter) share one stimulus stream; a driver queues expectations
// tagged with the cycle they apply to and a negedge monitor checks them.
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, id_valid, u1, u2, is_ld, ex_valid, flush;
  logic [31:0] instr_id, instr_ex;
  logic [9:0]  stg_rd;
  logic [1:0]  wren, jump;

  logic [1:0]  a_sel [3];
  logic [1:0]  b_sel [3];
  logic        pa [3], pb [3], stall [3], bub [3];
  logic [31:0] cnt0, cnt1;
  logic [3:0]  cnt4;

  fwd_hazard_unit #(.NUM_STAGES(2), .LOAD_LAT(1), .CNTW(32)) u_l1 (
    .i_clk(clk), .i_reset(reset), .i_instr_ID(instr_id), .i_id_valid(id_valid),
    .i_id_uses_rs1(u1), .i_id_uses_rs2(u2), .i_id_is_load(is_ld),
    .i_instr_EX(instr_ex), .i_ex_valid(ex_valid), .i_stg_rd(stg_rd),
    .i_stg_wren(wren), .i_stg_jump(jump), .i_flush(flush),
    .o_fwd_a_sel(a_sel[0]), .o_fwd_b_sel(b_sel[0]), .o_pc_four_a(pa[0]),
    .o_pc_four_b(pb[0]), .o_stall_id(stall[0]), .o_bubble_ex(bub[0]),
    .o_stall_cnt(cnt0));

  fwd_hazard_unit #(.NUM_STAGES(2), .LOAD_LAT(3), .CNTW(32)) u_l3 (
    .i_clk(clk), .i_reset(reset), .i_instr_ID(instr_id), .i_id_valid(id_valid),
    .i_id_uses_rs1(u1), .i_id_uses_rs2(u2), .i_id_is_load(is_ld),
    .i_instr_EX(instr_ex), .i_ex_valid(ex_valid), .i_stg_rd(stg_rd),
    .i_stg_wren(wren), .i_stg_jump(jump), .i_flush(flush),
    .o_fwd_a_sel(a_sel[1]), .o_fwd_b_sel(b_sel[1]), .o_pc_four_a(pa[1]),
    .o_pc_four_b(pb[1]), .o_stall_id(stall[1]), .o_bubble_ex(bub[1]),
    .o_stall_cnt(cnt1));

  fwd_hazard_unit #(.NUM_STAGES(2), .LOAD_LAT(4), .CNTW(4)) u_c4 (
    .i_clk(clk), .i_reset(reset), .i_instr_ID(instr_id), .i_id_valid(id_valid),
    .i_id_uses_rs1(u1), .i_id_uses_rs2(u2), .i_id_is_load(is_ld),
    .i_instr_EX(instr_ex), .i_ex_valid(ex_valid), .i_stg_rd(stg_rd),
    .i_stg_wren(wren), .i_stg_jump(jump), .i_flush(flush),
    .o_fwd_a_sel(a_sel[2]), .o_fwd_b_sel(b_sel[2]), .o_pc_four_a(pa[2]),
    .o_pc_four_b(pb[2]), .o_stall_id(stall[2]), .o_bubble_ex(bub[2]),
    .o_stall_cnt(cnt4));

  typedef struct {
    int          tag;
    int          inst;
    int          kind;   // 0 a_sel, 1 b_sel, 2 pc4_a, 3 pc4_b, 4 stall, 5 bubble, 6 cnt
    logic [31:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(int inst, int kind);
    case (kind)
      0: return 32'(a_sel[inst]);
      1: return 32'(b_sel[inst]);
      2: return 32'(pa[inst]);
      3: return 32'(pb[inst]);
      4: return 32'(stall[inst]);
      5: return 32'(bub[inst]);
      default: return (inst == 0) ? cnt0 : (inst == 1) ? cnt1 : 32'(cnt4);
    endcase
  endfunction

  exp_t        mon_e;
  logic [31:0] mon_act;

  // Monitor: at each negedge, retire every expectation tagged for this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].tag <= cyc) begin
      mon_e   = q.pop_front();
      mon_act = actual(mon_e.inst, mon_e.kind);
      checks++;
      if (mon_e.tag != cyc || mon_act !== mon_e.v) begin
        errors++;
        $display("FAIL %s inst%0d kind%0d: got %0d expected %0d (cycle %0d tag %0d)",
                 mon_e.name, mon_e.inst, mon_e.kind, mon_act, mon_e.v, cyc, mon_e.tag);
      end
    end
  end

  function automatic logic [31:0] rtype(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction

  function automatic logic [31:0] lw(logic [4:0] rd, logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'h03};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; id_valid = 0; u1 = 0; u2 = 0; is_ld = 0; ex_valid = 0; flush = 0;
    instr_id = 0; instr_ex = 0; stg_rd = 0; wren = 0; jump = 0;
  endtask

  task automatic expect_v(string n, int inst, int kind, logic [31:0] v);
    exp_t e;
    e.tag = cyc; e.inst = inst; e.kind = kind; e.v = v; e.name = n;
    q.push_back(e);
  endtask

  task automatic exp_fwd(string n, logic [1:0] a, logic [1:0] b, logic p_a, logic p_b);
    expect_v(n, 0, 0, 32'(a));
    expect_v(n, 0, 1, 32'(b));
    expect_v(n, 0, 2, 32'(p_a));
    expect_v(n, 0, 3, 32'(p_b));
  endtask

  task automatic exp_stall(string n, logic s0, logic s1, logic s2);
    expect_v(n, 0, 4, 32'(s0)); expect_v(n, 0, 5, 32'(s0));
    expect_v(n, 1, 4, 32'(s1)); expect_v(n, 1, 5, 32'(s1));
    expect_v(n, 2, 4, 32'(s2)); expect_v(n, 2, 5, 32'(s2));
  endtask

  task automatic exp_cnt(string n, int c0, int c1, int c2);
    expect_v(n, 0, 6, 32'(c0));
    expect_v(n, 1, 6, 32'(c1));
    expect_v(n, 2, 6, 32'(c2));
  endtask

  task automatic id_load(logic [4:0] rd);
    id_valid = 1; is_ld = 1; u1 = 1; u2 = 0; instr_id = lw(rd, 5'd1);
  endtask

  task automatic id_add(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic a, logic b);
    id_valid = 1; is_ld = 0; u1 = a; u2 = b; instr_id = rtype(rd, rs1, rs2);
  endtask

  // Leaves the current cycle idle with reset released and scoreboard clear.
  task automatic do_reset();
    tick(); idle(); reset = 1;
    tick(); reset = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle(); reset = 1;
    tick(); tick(); reset = 0;
    exp_stall("rst_stall", 0, 0, 0);
    exp_cnt("rst_cnt", 0, 0, 0);
    exp_fwd("rst_fwd", 0, 0, 0, 0);

    // Forwarding vectors
    tick(); ex_valid = 1; instr_ex = rtype(3, 1, 2);
    stg_rd = {5'd2, 5'd1}; wren = 2'b11;
    exp_fwd("fwd_s0a_s1b", 1, 2, 0, 0);
    tick(); stg_rd = {5'd1, 5'd1}; wren = 2'b11;
    exp_fwd("fwd_youngest", 1, 0, 0, 0);
    tick(); wren = 2'b10;
    exp_fwd("fwd_s0_off", 2, 0, 0, 0);
    tick(); ex_valid = 0;
    exp_fwd("fwd_ex_invalid", 0, 0, 0, 0);
    tick(); ex_valid = 1; instr_ex = rtype(3, 1, 5);
    stg_rd = {5'd5, 5'd9}; wren = 2'b11; jump = 2'b10;
    exp_fwd("fwd_jal_pc4", 0, 2, 0, 1);
    tick(); instr_ex = rtype(3, 0, 2); stg_rd = {5'd7, 5'd0}; wren = 2'b11; jump = 2'b00;
    exp_fwd("fwd_x0", 0, 0, 0, 0);
    tick(); instr_ex = rtype(3, 8, 8); stg_rd = {5'd8, 5'd8}; wren = 2'b11; jump = 2'b01;
    exp_fwd("fwd_both_jump0", 1, 1, 1, 1);

    // Load-use: lw x4 then add x6,x4,x4 held in ID
    do_reset();
    id_load(4);
    exp_stall("lu_load", 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(); id_add(6, 4, 4, 1, 1);
      exp_stall($sformatf("lu_dep%0d", i), i < 1, i < 3, i < 4);
    end
    tick(); idle();
    ex_valid = 1; instr_ex = rtype(6, 4, 4); stg_rd = {5'd4, 5'd6}; wren = 2'b10;
    exp_cnt("lu_cnt", 1, 3, 4);
    exp_fwd("lu_fwd_wb", 2, 2, 0, 0);

    // Independent after load, operand-use gating, x0 never scoreboarded
    do_reset();
    id_load(4);
    exp_stall("ind_load", 0, 0, 0);
    tick(); id_add(7, 5, 6, 1, 1);
    exp_stall("ind_b2b", 0, 0, 0);
    tick(); id_add(8, 0, 4, 1, 0);
    exp_stall("ind_unused_rs2", 0, 0, 0);
    tick(); id_add(9, 4, 4, 1, 1);
    exp_stall("ind_late_dep", 0, 1, 1);
    do_reset();
    id_load(0);
    tick(); id_add(6, 0, 0, 1, 1);
    exp_stall("x0_load", 0, 0, 0);

    // Flush kills the load now in EX
    do_reset();
    id_load(4);
    tick(); flush = 1; id_add(6, 4, 4, 1, 1);
    exp_stall("fl_flush_cycle", 0, 0, 0);
    tick(); flush = 0;
    exp_stall("fl_after", 0, 0, 0);

    // Reset in the middle of a stall
    do_reset();
    id_load(4);
    tick(); id_add(6, 4, 4, 1, 1);
    exp_stall("mr_stall", 1, 1, 1);
    tick(); reset = 1;
    tick(); reset = 0;
    exp_stall("mr_after", 0, 0, 0);
    exp_cnt("mr_cnt", 0, 0, 0);

    // Counter saturation on the 4-bit instance: 5 rounds of 4 stalls
    do_reset();
    for (int r = 0; r < 5; r++) begin
      tick(); id_load(7);
      exp_stall($sformatf("sat_ld%0d", r), 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
        tick(); id_add(6, 7, 7, 1, 1);
        expect_v("sat_stall", 2, 4, 32'd1);
      end
    end
    tick(); idle();
    exp_cnt("sat_cnt", 5, 15, 15);
    tick();
    expect_v("sat_hold", 2, 6, 32'd15);

    tick(); tick();
    if (q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      errors += q.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
